hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It drives the stall/flush controls of the PC register, IF_ID, ID_EX and EX_MEM pipeline registers. It resolves, in fixed priority, multi-cycle data-memory waits (with timeout), load-use data hazards and delay-slot annulment, and keeps a saturating stall-cycle counter.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive wait cycles before a memory access is aborted (≥2).
- `CNT_W`, default 16: stall counter width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source register numbers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction reads that source.
- `ex_rd`  in  5  destination of the instruction in EX.
- `ex_load`  in  1  the EX instruction is a load.
- `id_annul_ds`  in  1  the ID branch annuls its delay slot (decision precomputed by the branch unit).
- `mem_access`  in  1  the MEM stage performs a data-memory access this cycle.
- `mem_ready`  in  1  data memory completes this cycle.
- `pc_en`  out  1  PC/nPC register load enable.
- `ifid_stall`, `ifid_flush`  out  1 each  IF_ID hold / insert NOP.
- `idex_stall`, `idex_flush`  out  1 each  ID_EX hold / insert bubble.
- `exmem_stall`  out  1  EX_MEM hold.
- `mem_abort`  out  1  one-cycle pulse: access abandoned on timeout.
- `mem_err`  out  1  sticky timeout flag, cleared only by reset.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `pc_en` = 0.

## Operation
- Conditions, all combinational:
  - `lu` = `ex_load` & (`ex_rd` ≠ 0) & ((`id_use_rs1` & `id_rs1` == `ex_rd`) | (`id_use_rs2` & `id_rs2` == `ex_rd`)). Register 0 never causes a hazard.
  - `mw` = `mem_access` & ~`mem_ready` & ~`tmo`, where `tmo` = (state == WAIT) & (`wait_cnt` == `MEM_TIMEOUT`−1).
- Priority: `mw` > `lu` > annul.
  - `mw`: `pc_en`=0; `ifid_stall`, `idex_stall` and `exmem_stall` = 1; all flushes 0.
  - `lu` (and no `mw`): `pc_en`=0, `ifid_stall`=1, `idex_flush`=1. A single bubble is inserted; the load moves on to MEM, so `lu` drops the next cycle.
  - annul (`id_annul_ds` & no `mw` & no `lu`): `ifid_flush`=1 and `pc_en`=1; the delay slot in IF becomes a NOP. While a stall is active the annul request is ignored; the branch unit re-presents it once the branch is released.
  - None of these: `pc_en`=1 and every other control is 0.
- FSM states:
  - RUN: `wait_cnt`=0. `mw` → WAIT with `wait_cnt`=1.
  - WAIT: if `mem_ready` → RUN. Else if `tmo` → RUN, with `mem_abort`=1 that cycle and `mem_err` set at the edge. Else `wait_cnt`+1.
- On a timeout cycle the stall is released (`mw`=0) so the pipeline advances. EX_MEM treats the abort as a completed access with undefined load data; that is acceptable because `mem_err` flags it.
- `stall_cnt` increments every cycle `pc_en`=0 and saturates at all-ones.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = RUN, `wait_cnt` = 0, `mem_err` = 0, `stall_cnt` = 0.
  - Combinational outputs follow the inputs; with all inputs at 0: `pc_en`=1 and every other output 0.
- All stall/flush outputs have zero latency (combinational, same cycle as the inputs). Only the FSM, `mem_err` and `stall_cnt` update on the rising edge.
- A memory wait of N cycles (`mem_ready` low for N cycles, N < `MEM_TIMEOUT`) stalls for exactly N cycles. `mem_ready` high in the first cycle causes 0 stall cycles.
- With `mem_ready` never asserted, the stall lasts `MEM_TIMEOUT`−1 cycles, then `mem_abort` pulses for 1 cycle with stalls deasserted.
- Back-to-back accesses: a new `mw` in the cycle after WAIT→RUN re-enters WAIT with the counter restarted at 1.
- `lu` during `mw` is masked. It is re-evaluated when the stall ends; because EX is held, it then yields its single bubble.
- Reset asserted mid-WAIT aborts the wait without a `mem_abort` pulse.

## Structure
- Shared pipeline package holds the register-number width (5), the NOP encoding (32'd0), and the FSM state enumeration `hz_state_t` {RUN, WAIT}.
- Single module with no sub-modules. Hazard compare and priority logic are combinational; the FSM, timeout counter and stall counter are sequential.

## Test plan
- Load-use: `ex_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle with `pc_en`=0, `ifid_stall`=1, `idex_flush`=1. `stall_cnt` goes 0→1.
- Register-0 / unused source: `ex_rd`=0 with a match, or `id_use_rs1`=0 with `id_rs1`=`ex_rd` → no stall.
- Memory wait: `mem_access`=1 and `mem_ready` low for 3 cycles → exactly 3 stall cycles with `ifid_stall`, `idex_stall` and `exmem_stall` all high, then RUN. `stall_cnt`=3.
- Timeout (`MEM_TIMEOUT`=4): `mem_ready` held 0 → 3 stall cycles, then `mem_abort` pulse and `mem_err`=1 held until reset.
- Simultaneous `mw`, `lu` and `id_annul_ds` → only the `mw` controls are asserted. After `mem_ready`, the load-use bubble occurs once; annul is flushed only when re-presented with no stall.
- Reset asserted during WAIT cycle 2 → state RUN, counters 0, no `mem_abort` pulse, and `pc_en`=1 once inputs are idle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions for the five-stage core.
//   REG_W      - register-number width
//   NOP        - instruction encoding inserted by a flush
//   hz_state_t - hazard controller memory-wait FSM states
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [31:0] NOP = 32'd0;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for PC, IF_ID, ID_EX and EX_MEM.
// Fixed priority: memory wait > load-use > delay-slot annul.
// Ports:
//   clk, reset                  clock, async active-high reset
//   id_rs1/id_rs2, id_use_rs*   sources read by the ID instruction
//   ex_rd, ex_load              destination / load flag of the EX instruction
//   id_annul_ds                 ID branch annuls its delay slot
//   mem_access, mem_ready       MEM stage data-memory handshake
//   pc_en                       PC/nPC load enable
//   ifid_*/idex_*/exmem_stall   pipeline register hold / flush controls
//   mem_abort                   one-cycle pulse when a wait times out
//   mem_err                     sticky timeout flag
//   stall_cnt                   saturating count of cycles with pc_en low
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             id_annul_ds,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             mem_abort,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // wait_cnt never exceeds MEM_TIMEOUT-1
    localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] TMO_LAST = WCW'(MEM_TIMEOUT - 1);

    hz_state_t      state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
    logic           lu, mw, tmo;

    // register 0 is hardwired, so it never creates a dependency
    assign lu = ex_load && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    // on the timeout cycle the stall is dropped so the pipeline advances
    assign tmo = (state == WAIT) && (wait_cnt == TMO_LAST);
    assign mw  = mem_access && !mem_ready && !tmo;

    // priority-resolved pipeline controls
    always_comb begin
        pc_en       = 1'b1;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        if (mw) begin
            pc_en       = 1'b0;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
        end else if (id_annul_ds) begin
            ifid_flush = 1'b1;
        end
    end

    // memory-wait FSM: next state and abort pulse
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_abort    = 1'b0;
        case (state)
            RUN: begin
                wait_cnt_nxt = '0;
                if (mw) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WCW'(1);
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (tmo) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    mem_abort    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else if (mem_abort) begin
            mem_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus; a cycle-level behavioural model is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_hazard_ctrl;

    localparam int T     = 4;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_use_rs1 = 0, id_use_rs2 = 0, ex_load = 0;
    logic          id_annul_ds = 0, mem_access = 0, mem_ready = 0;
    logic          pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_stall, mem_abort, mem_err;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_load(ex_load), .id_annul_ds(id_annul_ds),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush),
        .exmem_stall(exmem_stall), .mem_abort(mem_abort),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // waiting : an access is outstanding and has already cost 'waited' stalls
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_err     = 0;
    int m_stalls  = 0;

    always @(negedge clk) begin
        bit hz, give_up, hold_mem, e_pc, e_ifs, e_iff, e_ids, e_idf, e_ems, e_abort;
        if (reset) begin
            m_waiting = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        end
        hz = ex_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        // an access that has already stalled T-1 cycles is abandoned
        give_up  = m_waiting && (m_waited == T - 1);
        hold_mem = mem_access && !mem_ready && !give_up;
        e_abort  = m_waiting && !mem_ready && give_up;
        e_pc  = !(hold_mem || hz);
        e_ifs = hold_mem || hz;
        e_ids = hold_mem;
        e_ems = hold_mem;
        e_idf = !hold_mem && hz;
        e_iff = !hold_mem && !hz && id_annul_ds;

        chk("pc_en", int'(pc_en), int'(e_pc));
        chk("ifid_stall", int'(ifid_stall), int'(e_ifs));
        chk("ifid_flush", int'(ifid_flush), int'(e_iff));
        chk("idex_stall", int'(idex_stall), int'(e_ids));
        chk("idex_flush", int'(idex_flush), int'(e_idf));
        chk("exmem_stall", int'(exmem_stall), int'(e_ems));
        chk("mem_abort", int'(mem_abort), int'(e_abort));
        chk("mem_err", int'(mem_err), int'(m_err));
        chk("stall_cnt", int'(stall_cnt), m_stalls);

        // state after the coming rising edge
        if (!reset) begin
            if (!e_pc && m_stalls < SMAX) m_stalls++;
            if (e_abort) m_err = 1;
            if (!m_waiting) begin
                if (hold_mem) begin m_waiting = 1; m_waited = 1; end
            end else if (mem_ready || give_up) begin
                m_waiting = 0; m_waited = 0;
            end else begin
                m_waited++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_load = 0; id_annul_ds = 0; mem_access = 0; mem_ready = 0;
    endtask

    task automatic set_lu();
        ex_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    endtask

    initial begin
        #1;
        chk("rst pc_en", int'(pc_en), 1);
        chk("rst stall_cnt", int'(stall_cnt), 0);
        chk("rst mem_err", int'(mem_err), 0);
        cyc(2); reset = 0; cyc();

        // load-use: one bubble
        set_lu(); #1;
        chk("lu pc_en", int'(pc_en), 0);
        chk("lu idex_flush", int'(idex_flush), 1);
        cyc(); idle(); #1;
        chk("lu stall_cnt", int'(stall_cnt), 1);
        chk("lu released", int'(pc_en), 1);

        // register 0 and unused source never hazard
        ex_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
        chk("r0 no stall", int'(pc_en), 1);
        cyc();
        ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 3; #1;
        chk("unused src", int'(pc_en), 1);
        cyc(); idle();

        // memory wait of 3 cycles
        mem_access = 1; mem_ready = 0; cyc(2); #1;
        chk("mw exmem_stall", int'(exmem_stall), 1);
        cyc(); mem_ready = 1; #1;
        chk("mw done pc_en", int'(pc_en), 1);
        cyc(); idle(); #1;
        chk("mw stall_cnt", int'(stall_cnt), 4);

        // annul on its own
        id_annul_ds = 1; #1;
        chk("annul flush", int'(ifid_flush), 1);
        cyc(); idle();

        // simultaneous wait, load-use and annul
        mem_access = 1; mem_ready = 0; set_lu(); id_annul_ds = 1; #1;
        chk("prio idex_flush", int'(idex_flush), 0);
        chk("prio ifid_flush", int'(ifid_flush), 0);
        cyc(2); mem_ready = 1; #1;
        chk("prio bubble", int'(idex_flush), 1);
        chk("prio no annul", int'(ifid_flush), 0);
        cyc(); ex_load = 0; mem_access = 0; mem_ready = 0; #1;
        chk("prio annul later", int'(ifid_flush), 1);
        cyc(); idle();

        // timeout with mem_ready never asserted
        mem_access = 1; mem_ready = 0; cyc(3); #1;
        chk("tmo abort", int'(mem_abort), 1);
        chk("tmo released", int'(pc_en), 1);
        cyc(); idle(); #1;
        chk("tmo mem_err", int'(mem_err), 1);
        cyc(3);
        chk("tmo err sticky", int'(mem_err), 1);

        // back-to-back accesses
        mem_access = 1; mem_ready = 0; cyc(2);
        mem_ready = 1; cyc();
        mem_ready = 0; cyc(2);
        mem_ready = 1; cyc(); idle(); cyc();

        // reset during WAIT cycle 2
        mem_access = 1; mem_ready = 0; cyc(2);
        reset = 1; #1;
        chk("rstw stall_cnt", int'(stall_cnt), 0);
        chk("rstw mem_err", int'(mem_err), 0);
        chk("rstw abort", int'(mem_abort), 0);
        idle(); #1;
        chk("rstw pc_en", int'(pc_en), 1);
        cyc(); reset = 0; cyc();
        mem_access = 1; mem_ready = 0; cyc(T); idle(); cyc();

        // saturation of the stall counter
        set_lu(); cyc(SMAX + 5);
        chk("sat stall_cnt", int'(stall_cnt), SMAX);
        idle(); cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
